// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: FSM states, step count,
// counter width and the address width helper.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Address bits needed to reach every element of an n x n matrix.
   function automatic int addr_width(input int n);
      return (n * n > 1) ? $clog2(n * n) : 1;
   endfunction

   // Number of STREAM steps: feed (2n-1 skewed steps) plus drain (n-1 steps).
   function automatic int step_count(input int n);
      return 3 * n - 2;
   endfunction

   // Width of the step counter t, which runs 0 .. 3n-3.
   function automatic int cnt_width(input int n);
      return $clog2(3 * n - 2);
   endfunction

   localparam int DEF_N          = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_STEPS      = step_count(DEF_N);
   localparam int DEF_CNT_WIDTH  = cnt_width(DEF_N);

endpackage

// File: rtl/systolic_feeder_if.sv
// Matrix-load / start / edge-operand bundle between the controller and the
// systolic feeder. The feeder sits on the slave side.
interface systolic_feeder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 4
);
   import systolic_pkg::*;

   localparam int AW = addr_width(N);

   logic                    wr_en_i;
   logic                    wr_sel_i;
   logic [AW-1:0]           wr_addr_i;
   logic [DATA_WIDTH-1:0]   wr_data_i;
   logic                    start_i;
   logic                    busy_o;
   logic                    done_o;
   logic                    arr_rst_no;
   logic [N*DATA_WIDTH-1:0] left_o;
   logic [N*DATA_WIDTH-1:0] up_o;

   modport slave (
      input  wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
      output busy_o, done_o, arr_rst_no, left_o, up_o
   );

   modport master (
      output wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
      input  busy_o, done_o, arr_rst_no, left_o, up_o
   );

endinterface

// File: rtl/systolic_feeder_skew_lane.sv
// One edge lane of the feeder: presents element (t - offset) of its stored
// vector while that slot lies inside the vector, and zero otherwise.
module skew_lane
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 4,
   parameter int CW         = cnt_width(N)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         en_i,
   input  logic [N-1:0][DATA_WIDTH-1:0] vec_i,
   input  logic [CW-1:0]                off_i,
   input  logic [CW-1:0]                t_i,
   output logic [DATA_WIDTH-1:0]        data_o
);

   logic [DATA_WIDTH-1:0] data_d;
   logic [DATA_WIDTH-1:0] data_q;

   // Select the element whose slot equals t - offset; at most one slot matches.
   always_comb begin
      data_d = '0;
      for (int k = 0; k < N; k++) begin
         data_d = data_d | ({DATA_WIDTH{en_i &&
                   ({1'b0, t_i} == ({1'b0, off_i} + (CW+1)'(k)))}} & vec_i[k]);
      end
   end

   // Register the lane operand so the edge of the array sees a clean flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/systolic_feeder.sv
// Feeder for an N x N systolic multiply array: stores A and B, clears the
// accumulators, then streams row i of A / column j of B with an i (resp. j)
// cycle skew, followed by drain steps, and pulses done when C is final.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   systolic_feeder_if.slave  bus
);

   localparam int CW     = cnt_width(N);
   localparam int LAST_T = step_count(N) - 1;

   logic [DATA_WIDTH-1:0] a_q [N*N];
   logic [DATA_WIDTH-1:0] b_q [N*N];

   state_e        state_q;
   logic [CW-1:0] t_q;
   logic          busy_q;
   logic          done_q;
   logic          arr_rst_n_q;

   logic          lane_en_s;
   logic [CW-1:0] lane_t_s;

   logic [N*DATA_WIDTH-1:0] left_s;
   logic [N*DATA_WIDTH-1:0] up_s;

   // Matrix storage: writes land only while idle so a run sees stable operands.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int e = 0; e < N*N; e++) begin
            a_q[e] <= '0;
            b_q[e] <= '0;
         end
      end else if (bus.wr_en_i && (state_q == IDLE) && (int'(bus.wr_addr_i) < N*N)) begin
         if (bus.wr_sel_i) begin
            b_q[bus.wr_addr_i] <= bus.wr_data_i;
         end else begin
            a_q[bus.wr_addr_i] <= bus.wr_data_i;
         end
      end
   end

   // Run sequencer: IDLE -> CLEAR -> STREAM(t = 0..3N-3) -> DONE, with the
   // status outputs registered from the state being entered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         t_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         arr_rst_n_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  state_q     <= CLEAR;
                  busy_q      <= 1'b1;
                  arr_rst_n_q <= 1'b0;
               end else begin
                  state_q     <= IDLE;
               end
            end
            CLEAR: begin
               state_q     <= STREAM;
               t_q         <= '0;
               arr_rst_n_q <= 1'b1;
            end
            STREAM: begin
               if (t_q == CW'(LAST_T)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  t_q     <= t_q + CW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               t_q         <= '0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
               arr_rst_n_q <= 1'b1;
            end
         endcase
      end
   end

   // Lanes register their operand one cycle ahead, so they look at the step
   // the sequencer is about to be in rather than the current one.
   assign lane_en_s = (state_q == CLEAR) ||
                      ((state_q == STREAM) && (t_q != CW'(LAST_T)));
   assign lane_t_s  = (state_q == STREAM) ? (t_q + CW'(1)) : '0;

   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [N-1:0][DATA_WIDTH-1:0] a_row_s;
      logic [N-1:0][DATA_WIDTH-1:0] b_col_s;

      for (genvar k = 0; k < N; k++) begin : g_elem
         assign a_row_s[k] = a_q[g*N + k];
         assign b_col_s[k] = b_q[k*N + g];
      end

      skew_lane #(.DATA_WIDTH(DATA_WIDTH), .N(N), .CW(CW)) u_row (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en_i   (lane_en_s),
         .vec_i  (a_row_s),
         .off_i  (CW'(g)),
         .t_i    (lane_t_s),
         .data_o (left_s[g*DATA_WIDTH +: DATA_WIDTH])
      );

      skew_lane #(.DATA_WIDTH(DATA_WIDTH), .N(N), .CW(CW)) u_col (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en_i   (lane_en_s),
         .vec_i  (b_col_s),
         .off_i  (CW'(g)),
         .t_i    (lane_t_s),
         .data_o (up_s[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.arr_rst_no = arr_rst_n_q;
   assign bus.left_o     = left_s;
   assign bus.up_o       = up_s;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed + randomized bench for systolic_feeder with a matrix-level
// reference: expected edge operands come from the skew rule, and a PE-array
// accumulation over the captured streams is compared with A*B.
module tb_systolic_feeder;
   import systolic_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int NS = 3 * N - 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   logic [DW-1:0]   ma [N][N];
   logic [DW-1:0]   mb [N][N];
   logic [N*DW-1:0] lcap [NS];
   logic [N*DW-1:0] ucap [NS];
   logic [63:0]     pe_c [N][N];

   systolic_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();

   systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] exp_left(input int t);
      logic [N*DW-1:0] v = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) v[i*DW +: DW] = ma[i][t-i];
      return v;
   endfunction

   function automatic logic [N*DW-1:0] exp_up(input int t);
      logic [N*DW-1:0] v = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < N) v[j*DW +: DW] = mb[t-j][j];
      return v;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = '0;
            mb[i][j] = '0;
         end
   endtask

   task automatic wr(input bit sel, input int addr, input logic [DW-1:0] d);
      bus.wr_en_i   = 1'b1;
      bus.wr_sel_i  = sel;
      bus.wr_addr_i = 4'(addr);
      bus.wr_data_i = d;
      @(negedge clk);
      bus.wr_en_i   = 1'b0;
      if (sel) mb[addr / N][addr % N] = d;
      else     ma[addr / N][addr % N] = d;
   endtask

   task automatic idle_check(input string tag, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         chk({tag, ".busy"}, 128'(bus.busy_o), 128'(0));
         chk({tag, ".done"}, 128'(bus.done_o), 128'(0));
         chk({tag, ".arr"},  128'(bus.arr_rst_no), 128'(1));
         chk({tag, ".left"}, 128'(bus.left_o), 128'(0));
         chk({tag, ".up"},   128'(bus.up_o), 128'(0));
      end
   endtask

   // Model of the PE grid: PE(i,j) at step s multiplies the row-i operand
   // issued at s-j with the column-j operand issued at s-i.
   task automatic pe_check(input string tag);
      logic [63:0] acc;
      logic [63:0] ref_v;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc = '0;
            for (int s = 0; s < NS; s++)
               if (s - j >= 0 && s - i >= 0)
                  acc = acc + 64'(lcap[s-j][i*DW +: DW]) * 64'(ucap[s-i][j*DW +: DW]);
            ref_v = '0;
            for (int k = 0; k < N; k++)
               ref_v = ref_v + 64'(ma[i][k]) * 64'(mb[k][j]);
            pe_c[i][j] = acc;
            chk($sformatf("%s.pe%0d%0d", tag, i, j), 128'(acc), 128'(ref_v));
         end
   endtask

   task automatic do_run(input bit cw, input bit csel, input int caddr,
                         input logic [DW-1:0] cdata, input int inj_k,
                         input int rst_k, input string tag);
      logic [N*DW-1:0] el;
      logic [N*DW-1:0] eu;
      int t;
      bit aborted = 1'b0;
      if (cw) begin
         bus.wr_en_i   = 1'b1;
         bus.wr_sel_i  = csel;
         bus.wr_addr_i = 4'(caddr);
         bus.wr_data_i = cdata;
         if (csel) mb[caddr / N][caddr % N] = cdata;
         else      ma[caddr / N][caddr % N] = cdata;
      end
      bus.start_i = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 3*N + 1; k++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         bus.wr_en_i = 1'b0;
         t = k - 2;
         if (k >= 2 && k <= 3*N - 1) begin
            el = exp_left(t);
            eu = exp_up(t);
         end else begin
            el = '0;
            eu = '0;
         end
         chk($sformatf("%s.busy@%0d", tag, k), 128'(bus.busy_o), 128'(k <= 3*N - 1));
         chk($sformatf("%s.arr@%0d", tag, k),  128'(bus.arr_rst_no), 128'(k != 1));
         chk($sformatf("%s.done@%0d", tag, k), 128'(bus.done_o), 128'(k == 3*N));
         chk($sformatf("%s.left@%0d", tag, k), 128'(bus.left_o), 128'(el));
         chk($sformatf("%s.up@%0d", tag, k),   128'(bus.up_o), 128'(eu));
         if (k >= 2 && k <= 3*N - 1) begin
            lcap[t] = bus.left_o;
            ucap[t] = bus.up_o;
         end
         if (k == inj_k) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_sel_i  = 1'b0;
            bus.wr_addr_i = 4'd0;
            bus.wr_data_i = 32'd99;
            bus.start_i   = 1'b1;
         end
         if (k == rst_k) begin
            #2 rst_n = 1'b0;
            #1;
            chk({tag, ".rst_busy"}, 128'(bus.busy_o), 128'(0));
            chk({tag, ".rst_done"}, 128'(bus.done_o), 128'(0));
            chk({tag, ".rst_arr"},  128'(bus.arr_rst_no), 128'(1));
            chk({tag, ".rst_left"}, 128'(bus.left_o), 128'(0));
            chk({tag, ".rst_up"},   128'(bus.up_o), 128'(0));
            clear_model();
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk({tag, ".post_busy"}, 128'(bus.busy_o), 128'(0));
            aborted = 1'b1;
            break;
         end
      end
      if (!aborted) pe_check(tag);
   endtask

   initial begin
      int ndone;
      int dpos [3];
      bit prev_done;
      bit consec;

      bus.wr_en_i   = 1'b0;
      bus.wr_sel_i  = 1'b0;
      bus.wr_addr_i = '0;
      bus.wr_data_i = '0;
      bus.start_i   = 1'b0;
      clear_model();

      // 1: reset values, then idle
      repeat (2) @(negedge clk);
      chk("t1.rst_arr",  128'(bus.arr_rst_no), 128'(1));
      chk("t1.rst_busy", 128'(bus.busy_o), 128'(0));
      rst_n = 1'b1;
      idle_check("t1", 5);

      // 2: A = identity, B sequential -> C = B
      for (int k = 0; k < N; k++)
         for (int j = 0; j < N; j++) begin
            if (k == j) wr(1'b0, k*N + j, 32'd1);
            wr(1'b1, k*N + j, 32'(4*k + j + 1));
         end
      do_run(1'b0, 1'b0, 0, '0, 0, 0, "t2");
      chk("t2.pe33_const", 128'(pe_c[3][3]), 128'(16));
      chk("t2.pe01_const", 128'(pe_c[0][1]), 128'(2));

      // 3: structured A and B, full stream checked against the skew rule
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            wr(1'b0, i*N + k, 32'(16*i + k + 1));
            wr(1'b1, i*N + k, 32'(100 + 4*i + k));
         end
      do_run(1'b0, 1'b0, 0, '0, 0, 0, "t3");
      chk("t3.left2_t5", 128'(lcap[5][2*DW +: DW]), 128'(36));
      chk("t3.left3_t5", 128'(lcap[5][3*DW +: DW]), 128'(51));
      chk("t3.left0_t5", 128'(lcap[5][0 +: DW]), 128'(0));
      chk("t3.up1_t5",   128'(ucap[5][1*DW +: DW]), 128'(0));

      // 4: write + start during STREAM t=1 are dropped
      do_run(1'b0, 1'b0, 0, '0, 3, 0, "t4");
      do_run(1'b0, 1'b0, 0, '0, 0, 0, "t4b");
      chk("t4b.a00", 128'(lcap[0][0 +: DW]), 128'(1));

      // 5: asynchronous reset at t=3, then an all-zero run
      do_run(1'b0, 1'b0, 0, '0, 0, 5, "t5");
      do_run(1'b0, 1'b0, 0, '0, 0, 0, "t5b");

      // random matrices, last write coincident with start
      for (int r = 0; r < 3; r++) begin
         for (int e = 0; e < N*N; e++) begin
            wr(1'b0, e, $urandom);
            wr(1'b1, e, $urandom);
         end
         do_run(1'b1, 1'($urandom_range(1)), $urandom_range(N*N - 1), $urandom,
                0, 0, $sformatf("rnd%0d", r));
      end

      // 6: start held high -> one run every 3N+1 cycles
      ndone     = 0;
      prev_done = 1'b0;
      consec    = 1'b0;
      bus.start_i = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (bus.done_o) begin
            if (prev_done) consec = 1'b1;
            if (ndone < 3) dpos[ndone] = k;
            ndone++;
         end
         prev_done = bus.done_o;
      end
      bus.start_i = 1'b0;
      chk("t6.ndone",  128'(ndone), 128'(3));
      chk("t6.done0",  128'(dpos[0]), 128'(3*N));
      chk("t6.done1",  128'(dpos[1]), 128'(2*(3*N) + 1));
      chk("t6.done2",  128'(dpos[2]), 128'(3*(3*N) + 2));
      chk("t6.consec", 128'(consec), 128'(0));
      repeat (10) @(negedge clk);
      chk("t6.idle_busy", 128'(bus.busy_o), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
